// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32 native memory port between two requesters,
// with a forced idle cycle between transactions and an optional downstream watchdog.
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        ds_valid,
  output logic        ds_instr,
  output logic [31:0] ds_addr,
  output logic [31:0] ds_wdata,
  output logic [3:0]  ds_wstrb,
  input  logic        ds_ready,
  input  logic [31:0] ds_rdata,
  output logic        timeout_err,
  output logic        timeout_id
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : int'(TIMEOUT_CYCLES) - 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(LAST_INT);
  localparam logic WATCHDOG_ON = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic [CW-1:0] count;

  logic        pick;
  logic        timeout_hit;
  logic        complete;
  logic [31:0] done_data;

  // On a tie the requester that did not win last time goes next.
  assign pick        = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
  assign timeout_hit = WATCHDOG_ON && (count == LAST_COUNT);
  // ds_ready takes priority over a watchdog expiring in the same cycle.
  assign complete    = ds_ready || timeout_hit;
  assign done_data   = ds_ready ? ds_rdata : TIMEOUT_RDATA;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      count       <= '0;
      ds_valid    <= 1'b0;
      ds_instr    <= 1'b0;
      ds_addr     <= '0;
      ds_wdata    <= '0;
      ds_wstrb    <= '0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= 1'b0;
    end else begin
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant      <= pick;
            last_grant <= pick;
            count      <= '0;
            ds_valid   <= 1'b1;
            ds_instr   <= pick ? m1_instr : m0_instr;
            ds_addr    <= pick ? m1_addr  : m0_addr;
            ds_wdata   <= pick ? m1_wdata : m0_wdata;
            ds_wstrb   <= pick ? m1_wstrb : m0_wstrb;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (complete) begin
            ds_valid <= 1'b0;
            if (grant) begin
              m1_ready <= 1'b1;
              m1_rdata <= done_data;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= done_data;
            end
            if (!ds_ready) begin
              timeout_err <= 1'b1;
              timeout_id  <= grant;
            end
            state <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        // The finishing requester still shows valid here, so no grant is made.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: directed scenarios with literal expectations,
// then randomized requesters/downstream checked every cycle against a transaction model.
module tb_picorv32_mem_arbiter;

  localparam int unsigned TO = 8;
  localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]       req_valid, req_instr;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][3:0]  req_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ds_valid, ds_instr, ds_ready;
  logic [31:0] ds_addr, ds_wdata, ds_rdata;
  logic [3:0]  ds_wstrb;
  logic        timeout_err, timeout_id;

  logic [1:0]       rdy;
  logic [1:0][31:0] rdat;
  assign rdy  = {m1_ready, m0_ready};
  assign rdat = {m1_rdata, m0_rdata};

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(TO_RDATA)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(req_valid[0]), .m0_instr(req_instr[0]), .m0_addr(req_addr[0]),
    .m0_wdata(req_wdata[0]), .m0_wstrb(req_wstrb[0]), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(req_valid[1]), .m1_instr(req_instr[1]), .m1_addr(req_addr[1]),
    .m1_wdata(req_wdata[1]), .m1_wstrb(req_wstrb[1]), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ds_valid(ds_valid), .ds_instr(ds_instr), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_wstrb(ds_wstrb), .ds_ready(ds_ready), .ds_rdata(ds_rdata),
    .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, how long it has waited, and the pause after it.
  logic             m_active, m_gap, m_owner, m_last, timed;
  int               m_waited;
  logic             e_ds_valid, e_ds_instr, e_err, e_id;
  logic [31:0]      e_ds_addr, e_ds_wdata;
  logic [3:0]       e_ds_wstrb;
  logic [1:0]       e_ready;
  logic [1:0][31:0] e_rdata;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_active = 0; m_gap = 0; m_last = 1; m_owner = 0; m_waited = 0;
      e_ds_valid = 0; e_ds_instr = 0; e_ds_addr = 0; e_ds_wdata = 0; e_ds_wstrb = 0;
      e_ready = 0; e_rdata = '0; e_err = 0; e_id = 0;
    end else begin
      e_ready = 0;
      e_err = 0;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_active) begin
        if (ds_ready || m_waited == int'(TO) - 1) begin
          timed = !ds_ready;
          e_rdata[m_owner] = timed ? TO_RDATA : ds_rdata;
          e_ready[m_owner] = 1;
          e_ds_valid = 0;
          m_active = 0;
          m_gap = 1;
          if (timed) begin
            e_err = 1;
            e_id = m_owner;
          end
          $display("txn m%0d %s addr=%h wstrb=%b rdata=%h timeout=%0d waited=%0d",
                   m_owner, (e_ds_wstrb == 0) ? "rd" : "wr", e_ds_addr, e_ds_wstrb,
                   e_rdata[m_owner], timed, m_waited + 1);
        end else begin
          m_waited++;
        end
      end else if (req_valid != 2'b00) begin
        m_owner = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        m_last = m_owner;
        m_active = 1;
        m_waited = 0;
        e_ds_valid = 1;
        e_ds_instr = req_instr[m_owner];
        e_ds_addr  = req_addr[m_owner];
        e_ds_wdata = req_wdata[m_owner];
        e_ds_wstrb = req_wstrb[m_owner];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ds_valid", ds_valid, e_ds_valid);
      chk("ds_instr", ds_instr, e_ds_instr);
      chk("ds_addr", ds_addr, e_ds_addr);
      chk("ds_wdata", ds_wdata, e_ds_wdata);
      chk("ds_wstrb", ds_wstrb, e_ds_wstrb);
      chk("m0_ready", m0_ready, e_ready[0]);
      chk("m1_ready", m1_ready, e_ready[1]);
      chk("m0_rdata", m0_rdata, e_rdata[0]);
      chk("m1_rdata", m1_rdata, e_rdata[1]);
      chk("timeout_err", timeout_err, e_err);
      chk("timeout_id", timeout_id, e_id);
    end
  end

  task automatic new_req(input int i);
    req_valid[i] = 1'b1;
    req_instr[i] = 1'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_wstrb[i] = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid[i] = 1'b1;
    req_instr[i] = 1'b0;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_wstrb[i] = s;
  endtask

  int hi;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_instr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    ds_ready = 1'b0; ds_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ds_valid", ds_valid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_timeout_id", timeout_id, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Tie after reset: m0 read wins, then m1 write.
    set_req(0, 32'h0000_1000, 32'h0, 4'b0000);
    set_req(1, 32'h0000_2004, 32'hAABB_CCDD, 4'b0101);
    @(negedge clk);
    chk("tie_ds_valid", ds_valid, 1);
    chk("tie_ds_addr", ds_addr, 32'h0000_1000);
    chk("rd_ds_wstrb", ds_wstrb, 0);
    @(negedge clk);
    @(negedge clk);
    ds_ready = 1'b1; ds_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("rd_m0_ready", m0_ready, 1);
    chk("rd_m0_rdata", m0_rdata, 32'h1122_3344);
    chk("rd_m1_ready", m1_ready, 0);
    chk("rd_ds_valid", ds_valid, 0);
    ds_ready = 1'b0; req_valid[0] = 1'b0;
    @(negedge clk);
    chk("gap_ds_valid", ds_valid, 0);
    chk("gap_m0_ready", m0_ready, 0);
    @(negedge clk);
    chk("wr_ds_addr", ds_addr, 32'h0000_2004);
    chk("wr_ds_wstrb", ds_wstrb, 4'b0101);
    chk("wr_ds_wdata", ds_wdata, 32'hAABB_CCDD);
    @(negedge clk);
    chk("wr_ds_addr_hold", ds_addr, 32'h0000_2004);
    ds_ready = 1'b1; ds_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("wr_m1_ready", m1_ready, 1);
    chk("wr_m0_ready", m0_ready, 0);
    chk("wr_m0_rdata_hold", m0_rdata, 32'h1122_3344);
    ds_ready = 1'b0; req_valid[1] = 1'b0;
    @(negedge clk);

    // Watchdog expiry with no ds_ready at all.
    set_req(0, 32'h0000_3000, 32'h0, 4'b0000);
    hi = 0;
    for (int k = 0; k < 30 && !m0_ready; k++) begin
      @(negedge clk);
      if (ds_valid) hi++;
    end
    chk("to_busy_len", hi, TO);
    chk("to_m0_ready", m0_ready, 1);
    chk("to_err", timeout_err, 1);
    chk("to_m0_rdata", m0_rdata, TO_RDATA);
    chk("to_id", timeout_id, 0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", timeout_err, 0);

    // ds_ready arriving on the last allowed cycle completes normally.
    set_req(0, 32'h0000_3004, 32'h0, 4'b0000);
    hi = 0;
    for (int k = 0; k < 30 && !m0_ready; k++) begin
      @(negedge clk);
      if (ds_valid) hi++;
      if (ds_valid && hi == int'(TO)) begin
        ds_ready = 1'b1; ds_rdata = 32'h5566_7788;
      end
    end
    chk("late_m0_ready", m0_ready, 1);
    chk("late_err", timeout_err, 0);
    chk("late_m0_rdata", m0_rdata, 32'h5566_7788);
    ds_ready = 1'b0; req_valid[0] = 1'b0;
    @(negedge clk);

    // Reset while busy drops the transaction; the held request is then regranted.
    set_req(1, 32'h0000_4000, 32'h1234_5678, 4'b1111);
    @(negedge clk);
    chk("mrst_busy", ds_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_ds_valid", ds_valid, 0);
    chk("mrst_m1_ready", m1_ready, 0);
    chk("mrst_ds_addr", ds_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_regrant", ds_valid, 1);
    chk("mrst_regrant_addr", ds_addr, 32'h0000_4000);
    ds_ready = 1'b1; ds_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("mrst_m1_ready", m1_ready, 1);
    ds_ready = 1'b0; req_valid[1] = 1'b0;
    @(negedge clk);

    // Randomized traffic: requesters hold valid until ready, downstream answers at random.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && rdy[i]) begin
          if ($urandom % 3 == 0) new_req(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom % 2 == 0) begin
          new_req(i);
        end
      end
      ds_ready = ($urandom % 4 == 0);
      ds_rdata = $urandom;
      reset = ($urandom % 400 == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
- Two-requester arbiter sharing one PicoRV32 native memory port, and hence one FreeAHB master adapter, between two native-interface masters (two cores, or split instruction/data ports).
- Round-robin grant; one transaction owns the downstream port until it completes.
- Inserts a mandatory idle cycle between transactions so the downstream adapter returns to idle.
- Optional watchdog aborts a hung downstream transaction and reports it.

Parameters:
- TIMEOUT_CYCLES, 1024, BUSY cycles without ds_ready before abort; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'h0000_0000, read data returned to a requester on abort.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_valid, m1_valid  in  1  requester transaction request; held until that requester's ready
- m0_instr, m1_instr  in  1  instruction-fetch flag
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_wstrb, m1_wstrb  in  4  byte strobes; 0 = read
- m0_ready, m1_ready  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  32  read data, valid while the matching ready is high
- ds_valid  out  1  downstream request
- ds_instr  out  1  downstream instruction flag
- ds_addr  out  32  downstream address
- ds_wdata  out  32  downstream write data
- ds_wstrb  out  4  downstream strobes
- ds_ready  in  1  downstream completion
- ds_rdata  in  32  downstream read data
- timeout_err  out  1  one-cycle pulse on watchdog abort
- timeout_id  out  1  requester of the last abort; sticky

Behaviour:
- All outputs registered.
- Reset values:
  - ds_valid=0, ds_instr=0, ds_addr=0, ds_wdata=0, ds_wstrb=0.
  - m*_ready=0, m*_rdata=0.
  - timeout_err=0, timeout_id=0.
  - last_grant=1, so m0 wins the first tie.
  - state=IDLE, counter=0.
- Reset is synchronous and overrides everything. Mid-transaction reset: ds_valid=0 at the next edge, no ready pulse is issued, and the aborted transaction is dropped.
- IDLE:
  - Neither valid: stay in IDLE.
  - Exactly one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - On grant: latch the granted instr/addr/wdata/wstrb onto ds_*, set ds_valid=1, last_grant=grant, counter=0, go to BUSY.
  - Latency: valid sampled at edge N gives ds_valid high from edge N.
- BUSY:
  - ds_* held stable.
  - On ds_ready=1: ds_valid<=0, granted m*_rdata<=ds_rdata, granted m*_ready<=1, go to DONE. Reads and writes are handled identically.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: ds_valid<=0, granted m*_rdata<=TIMEOUT_RDATA, m*_ready<=1, timeout_err<=1, timeout_id<=grant, go to DONE.
  - Otherwise counter increments; width is clog2(TIMEOUT_CYCLES)+1 bits, with no wrap possible before the compare.
  - ds_ready and the timeout condition in the same cycle: ds_ready wins and no error is raised.
- DONE (exactly one cycle):
  - m*_ready and timeout_err cleared at the next edge.
  - ds_valid stays 0, giving the downstream adapter one idle cycle.
  - No grant is made, since the completing requester still shows valid here.
  - Go to IDLE.
- Only the granted requester's ready/rdata change; the other requester's rdata holds its previous value.
- A requester dropping valid while granted is illegal. The arbiter ignores it and completes normally.
- ds_ready seen in IDLE or DONE is ignored.
- Back-to-back throughput: with both requesters saturated, grants alternate, one transaction per (downstream latency + 2) cycles.

Test Plan:
- Single read: m0 read addr 0x1000, ds_ready with rdata 0x11223344 three cycles after ds_valid -> ds_addr=0x1000, ds_wstrb=0, m0_ready pulse 1 cycle later with m0_rdata=0x11223344, ds_valid low for exactly one DONE cycle.
- Tie after reset: m0 and m1 both valid in the same cycle -> m0 granted first, then m1. With both kept requesting: grant order m0,m1,m0,m1; m1 never starved.
- Write pass-through: m1 wstrb=4'b0101, wdata=0xAABBCCDD, addr 0x2004 -> ds_wstrb=0101, ds_wdata=0xAABBCCDD, ds_addr=0x2004 stable until ds_ready; m1_ready pulse only, m0_ready stays 0.
- Timeout: TIMEOUT_CYCLES=8, ds_ready never asserted -> ds_valid drops after 8 BUSY cycles; m0_ready=1 with rdata=TIMEOUT_RDATA; timeout_err 1-cycle pulse, timeout_id=0. Repeat with ds_ready on cycle 8 -> normal completion, no error.
- Reset mid-BUSY: assert reset for 1 cycle while ds_valid=1 -> all outputs at reset values next edge, no ready pulse; the next m1 request is granted normally.
- Idle gap: m0 re-asserts valid the cycle after its ready while m1 is idle -> ds_valid shows exactly one low cycle between transactions.
